// File: rtl/dmem_resp_pkg.sv
// Shared definitions for the data-memory responder:
// access-size encodings, FSM states and the data width.
package dmem_resp_pkg;

    localparam int DATA_W = 32;

    localparam logic [1:0] SZ_BYTE = 2'd0;
    localparam logic [1:0] SZ_HALF = 2'd1;
    localparam logic [1:0] SZ_WORD = 2'd2;

    typedef enum logic {
        S_IDLE,
        S_RMW
    } state_t;

    // True when the access cannot be served at this byte offset.
    function automatic logic misaligned(
        input logic [1:0] size,
        input logic [1:0] off
    );
        logic bad;
        bad = 1'b0;
        unique case (size)
            SZ_BYTE: bad = 1'b0;
            SZ_HALF: bad = off[0];
            SZ_WORD: bad = (off != 2'b00);
            default: bad = 1'b1;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/dmem_ram.sv
// DEPTH x 32 data array: one synchronous read port and one
// write port, no reset so it maps onto block RAM.
module dmem_ram
    import dmem_resp_pkg::*;
#(
    parameter int DEPTH = 256
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  logic [DATA_W-1:0]        wdata,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output logic [DATA_W-1:0]        rdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    // Registered read, independent write.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        rdata <= mem[raddr];
    end

endmodule

// File: rtl/dmem_resp.sv
// Data-memory responder: load extension, sub-word
// read-modify-write and misalignment reporting.
module dmem_resp
    import dmem_resp_pkg::*;
#(
    parameter int DEPTH = 256
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    input  logic [31:0]       req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              resp_valid,
    output logic [DATA_W-1:0] resp_rdata,
    output logic              resp_err
);

    localparam int AW = $clog2(DEPTH);

    state_t state;
    state_t state_nx;

    logic          accept;
    logic          bad;
    logic [AW-1:0] idx;

    logic          ram_we;
    logic [AW-1:0] ram_waddr;
    logic [31:0]   ram_wdata;
    logic [31:0]   ram_rdata;

    logic [AW-1:0] rmw_idx;
    logic [15:0]   rmw_data;
    logic          rmw_half;
    logic [1:0]    rmw_off;
    logic [31:0]   merged;

    logic          rv_q;
    logic          err_q;
    logic          ld_q;
    logic          uns_q;
    logic [1:0]    sz_q;
    logic [1:0]    off_q;
    logic [7:0]    lane_b;
    logic [15:0]   lane_h;
    logic [31:0]   ld_data;

    logic          addr_unused;

    assign addr_unused = ^req_addr[31:AW+2];

    assign req_ready = (state == S_IDLE);
    assign accept    = req_valid && req_ready && !rst;
    assign bad       = misaligned(req_size, req_addr[1:0]);
    assign idx       = req_addr[AW+1:2];

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next state and RAM write port steering.
    always_comb begin
        state_nx  = state;
        ram_we    = 1'b0;
        ram_waddr = idx;
        ram_wdata = req_wdata;
        unique case (state)
            S_IDLE: begin
                if (accept && !bad && req_we) begin
                    if (req_size == SZ_WORD) begin
                        ram_we = 1'b1;
                    end else begin
                        state_nx = S_RMW;
                    end
                end
            end
            S_RMW: begin
                ram_we    = 1'b1;
                ram_waddr = rmw_idx;
                ram_wdata = merged;
                state_nx  = S_IDLE;
            end
        endcase
    end

    // Capture the sub-word store until its merge cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rmw_idx  <= '0;
            rmw_data <= '0;
            rmw_half <= 1'b0;
            rmw_off  <= 2'b00;
        end else if (accept) begin
            rmw_idx  <= idx;
            rmw_data <= req_wdata[15:0];
            rmw_half <= (req_size == SZ_HALF);
            rmw_off  <= req_addr[1:0];
        end
    end

    // New lanes replace the addressed bytes of the old word.
    always_comb begin
        merged = ram_rdata;
        if (rmw_half) begin
            merged[{rmw_off[1], 4'b0000} +: 16] = rmw_data;
        end else begin
            merged[{rmw_off, 3'b000} +: 8] = rmw_data[7:0];
        end
    end

    // Response pipeline: one cycle after accept, or after RMW.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rv_q  <= 1'b0;
            err_q <= 1'b0;
            ld_q  <= 1'b0;
            uns_q <= 1'b0;
            sz_q  <= SZ_BYTE;
            off_q <= 2'b00;
        end else begin
            rv_q  <= 1'b0;
            err_q <= 1'b0;
            ld_q  <= 1'b0;
            if (state == S_RMW) begin
                rv_q <= 1'b1;
            end else if (accept) begin
                sz_q  <= req_size;
                uns_q <= req_unsigned;
                off_q <= req_addr[1:0];
                if (bad) begin
                    rv_q  <= 1'b1;
                    err_q <= 1'b1;
                end else if (!req_we) begin
                    rv_q <= 1'b1;
                    ld_q <= 1'b1;
                end else if (req_size == SZ_WORD) begin
                    rv_q <= 1'b1;
                end
            end
        end
    end

    // Lane select and sign/zero extension of the read word.
    always_comb begin
        lane_b = ram_rdata[{off_q, 3'b000} +: 8];
        lane_h = ram_rdata[{off_q[1], 4'b0000} +: 16];
        unique case (sz_q)
            SZ_BYTE: ld_data = {{24{~uns_q & lane_b[7]}}, lane_b};
            SZ_HALF: ld_data = {{16{~uns_q & lane_h[15]}}, lane_h};
            default: ld_data = ram_rdata;
        endcase
    end

    assign resp_valid = rv_q;
    assign resp_err   = err_q;
    assign resp_rdata = (rv_q && ld_q) ? ld_data : '0;

    dmem_ram #(
        .DEPTH(DEPTH)
    ) u_ram (
        .clk  (clk),
        .we   (ram_we),
        .waddr(ram_waddr),
        .wdata(ram_wdata),
        .raddr(idx),
        .rdata(ram_rdata)
    );

endmodule

// File: tb/tb_dmem_resp.sv
// Bench for dmem_resp: directed scenarios plus random
// traffic checked against a transaction-level memory model.
module tb_dmem_resp;

    localparam int DEPTH = 256;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [1:0]  req_size = 2'd0;
    logic        req_unsigned = 1'b0;
    logic [31:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;

    always #5 clk = ~clk;

    dmem_resp #(
        .DEPTH(DEPTH)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_we      (req_we),
        .req_size    (req_size),
        .req_unsigned(req_unsigned),
        .req_addr    (req_addr),
        .req_wdata   (req_wdata),
        .resp_valid  (resp_valid),
        .resp_rdata  (resp_rdata),
        .resp_err    (resp_err)
    );

    typedef struct {
        int          due;
        logic [31:0] rdata;
        logic        err;
        logic        wr;
        int          widx;
        logic [31:0] wval;
    } exp_t;

    exp_t        q[$];
    logic [31:0] mem [DEPTH];
    int          cyc = 0;
    int          rmw_cyc = -1;
    int          n_chk = 0;
    int          n_pass = 0;
    int          ready_low = 0;
    logic [31:0] last_rdata = '0;
    logic        last_err = 1'b0;

    task automatic check(input string tag,
                         input logic [31:0] got,
                         input logic [31:0] want);
        n_chk++;
        if (got === want) n_pass++;
        else $display("FAIL %s: got %h want %h", tag, got, want);
    endtask

    function automatic logic is_bad(input logic [1:0] sz,
                                    input logic [31:0] a);
        return sz == 2'd3 || (sz == 2'd1 && a % 2 != 0) ||
               (sz == 2'd2 && a % 4 != 0);
    endfunction

    function automatic logic [31:0] load_val(input logic [31:0] w,
                                             input logic [1:0] sz,
                                             input logic uns,
                                             input logic [31:0] a);
        int sh;
        int v;
        sh = int'(a % 4) * 8;
        if (sz == 2'd2) return w;
        if (sz == 2'd0) begin
            v = int'((w >> sh) & 32'hFF);
            if (!uns && v >= 128) v -= 256;
        end else begin
            v = int'((w >> sh) & 32'hFFFF);
            if (!uns && v >= 32768) v -= 65536;
        end
        return v;
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] w,
                                          input logic [1:0] sz,
                                          input logic [31:0] a,
                                          input logic [31:0] d);
        int sh;
        logic [31:0] m;
        sh = int'(a % 4) * 8;
        m = (sz == 2'd0) ? 32'hFF : 32'hFFFF;
        return (w & ~(m << sh)) | ((d & m) << sh);
    endfunction

    // One clock cycle: drive, check at negedge, model acceptance.
    task automatic cycle(input logic v, input logic we,
                         input logic [1:0] sz, input logic uns,
                         input logic [31:0] a, input logic [31:0] d,
                         output logic acc);
        exp_t e;
        int   ix;
        req_valid = v;
        req_we = we;
        req_size = sz;
        req_unsigned = uns;
        req_addr = a;
        req_wdata = d;
        @(negedge clk);
        if (q.size() > 0 && q[0].due == cyc) begin
            check("resp_valid", resp_valid, 1);
            check("resp_rdata", resp_rdata, q[0].rdata);
            check("resp_err", resp_err, q[0].err);
            last_rdata = resp_rdata;
            last_err = resp_err;
            if (q[0].wr) mem[q[0].widx] = q[0].wval;
            void'(q.pop_front());
        end else begin
            check("no_resp", resp_valid, 0);
        end
        check("req_ready", req_ready, cyc != rmw_cyc);
        if (!req_ready) ready_low++;
        acc = v && req_ready;
        if (acc) begin
            ix = int'((a >> 2) % DEPTH);
            e.due = cyc + 1;
            e.rdata = '0;
            e.err = 1'b0;
            e.wr = 1'b0;
            e.widx = ix;
            e.wval = '0;
            if (is_bad(sz, a)) begin
                e.err = 1'b1;
            end else if (!we) begin
                e.rdata = load_val(mem[ix], sz, uns, a);
            end else if (sz == 2'd2) begin
                mem[ix] = d;
            end else begin
                e.due = cyc + 2;
                e.wr = 1'b1;
                e.wval = merge(mem[ix], sz, a, d);
                rmw_cyc = cyc + 1;
            end
            q.push_back(e);
        end
        @(posedge clk);
        cyc++;
        #1;
    endtask

    task automatic issue(input logic we, input logic [1:0] sz,
                         input logic uns, input logic [31:0] a,
                         input logic [31:0] d);
        logic acc;
        int   n;
        acc = 1'b0;
        n = 0;
        while (!acc && n < 8) begin
            cycle(1'b1, we, sz, uns, a, d, acc);
            n++;
        end
        if (!acc) check("accept_timeout", 0, 1);
    endtask

    task automatic idle(input int n);
        logic acc;
        repeat (n) cycle(1'b0, 1'b0, 2'd0, 1'b0, '0, '0, acc);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        req_valid = 1'b0;
        q.delete();
        rmw_cyc = -1;
        repeat (2) begin
            @(negedge clk);
            check("rst_valid", resp_valid, 0);
            check("rst_rdata", resp_rdata, 0);
            check("rst_err", resp_err, 0);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

    initial begin
        logic        acc;
        logic        v;
        logic        we;
        logic [1:0]  sz;
        logic [31:0] a;

        do_reset();

        // Word store then load, back to back.
        issue(1'b1, 2'd2, 1'b0, 32'h10, 32'hDEADBEEF);
        issue(1'b0, 2'd2, 1'b0, 32'h10, '0);
        idle(2);
        check("word_rd", last_rdata, 32'hDEADBEEF);

        // Sign/zero extension.
        issue(1'b1, 2'd2, 1'b0, 32'h20, 32'h80FF7F01);
        issue(1'b0, 2'd0, 1'b0, 32'h23, '0);
        idle(2);
        check("lb_23", last_rdata, 32'hFFFFFF80);
        issue(1'b0, 2'd1, 1'b1, 32'h22, '0);
        idle(2);
        check("lhu_22", last_rdata, 32'h000080FF);
        issue(1'b0, 2'd0, 1'b0, 32'h20, '0);
        idle(2);
        check("lb_20", last_rdata, 32'h00000001);

        // Sub-word merge with a stalled follow-on load.
        issue(1'b1, 2'd2, 1'b0, 32'h30, 32'h11223344);
        ready_low = 0;
        issue(1'b1, 2'd0, 1'b0, 32'h31, 32'h000000AA);
        issue(1'b0, 2'd2, 1'b0, 32'h30, '0);
        idle(2);
        check("sb_merge", last_rdata, 32'h1122AA44);
        check("stall_len", ready_low, 1);

        // Misalignment.
        issue(1'b1, 2'd2, 1'b0, 32'h40, 32'h12345678);
        issue(1'b0, 2'd2, 1'b0, 32'h42, '0);
        idle(2);
        check("mis_err", last_err, 1);
        check("mis_rdata", last_rdata, 0);
        issue(1'b1, 2'd1, 1'b0, 32'h41, 32'h0000BEEF);
        idle(2);
        check("mis_st_err", last_err, 1);
        issue(1'b0, 2'd2, 1'b0, 32'h40, '0);
        idle(2);
        check("mis_keep", last_rdata, 32'h12345678);

        // Reset during RMW abandons the merge.
        issue(1'b1, 2'd2, 1'b0, 32'h50, 32'h55555555);
        idle(2);
        issue(1'b1, 2'd1, 1'b0, 32'h50, 32'h0000BEEF);
        do_reset();
        issue(1'b0, 2'd2, 1'b0, 32'h50, '0);
        idle(2);
        check("rst_rmw", last_rdata, 32'h55555555);

        // Address wrap modulo DEPTH*4.
        issue(1'b1, 2'd2, 1'b0, 32'h400, 32'hCAFEF00D);
        issue(1'b0, 2'd2, 1'b0, 32'h000, '0);
        idle(2);
        check("wrap", last_rdata, 32'hCAFEF00D);

        // Random traffic over a small window of words.
        for (int i = 0; i < 8; i++) begin
            issue(1'b1, 2'd2, 1'b0, i * 4, $urandom);
        end
        for (int i = 0; i < 800; i++) begin
            v  = ($urandom_range(0, 9) < 7);
            we = $urandom_range(0, 1) != 0;
            sz = 2'($urandom_range(0, 3));
            a  = ($urandom & 32'hFFFFFC00) |
                 32'($urandom_range(0, 31));
            cycle(v, we, sz, 1'($urandom_range(0, 1)), a,
                  $urandom, acc);
        end
        idle(3);
        check("drain", q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
